// File: rtl/greeting_rx.sv
`default_nettype none
// ============================================================================
// Module   : greeting_rx
// Purpose  : Line receiver; buffers characters up to a 0x0A terminator, holds
//            the line for a consumer and checks terminator spacing.
// Revision : 1.0
// ============================================================================
module greeting_rx #(
    parameter int MAX_LEN = 32,
    parameter int PERIOD  = 200000,
    parameter int TOTAL   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_data,
    output logic                       line_valid,
    input  logic                       line_ready,
    output logic [$clog2(MAX_LEN):0]   line_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    output logic [31:0]                msg_cnt,
    output logic                       period_err,
    output logic                       overflow_err,
    output logic                       done
);

    localparam int             AW        = $clog2(MAX_LEN);
    localparam logic [AW:0]    c_MAX_LEN = (AW+1)'(MAX_LEN);
    localparam logic [31:0]    c_PERIOD  = 32'(PERIOD);
    localparam logic [31:0]    c_TOTAL   = 32'(TOTAL);

    localparam logic [1:0] c_RECV = 2'd0;
    localparam logic [1:0] c_HOLD = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_line_len;
    logic [31:0] r_msg_cnt;
    logic [31:0] r_gap;
    logic        r_first;
    logic        r_period_err;
    logic        r_overflow_err;
    logic [7:0]  r_buf [MAX_LEN];

    logic w_xfer;
    logic w_term;
    logic w_char;
    logic w_room;

    assign w_xfer = in_valid && in_ready;
    assign w_term = w_xfer && (in_data == 8'h0A);
    assign w_char = w_xfer && (in_data != 8'h0A);
    assign w_room = (r_wr_ptr < c_MAX_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_RECV;
            r_wr_ptr       <= '0;
            r_line_len     <= '0;
            r_msg_cnt      <= '0;
            r_gap          <= '0;
            r_first        <= 1'b1;
            r_period_err   <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            if (r_gap != '1) begin
                r_gap <= r_gap + 32'd1;
            end
            case (r_state)
                c_RECV: begin
                    if (w_term) begin
                        r_line_len <= r_wr_ptr;
                        r_wr_ptr   <= '0;
                        r_msg_cnt  <= r_msg_cnt + 32'd1;
                        // Gap restarts at 1 so equal spacing of PERIOD edges reads as PERIOD.
                        r_gap      <= 32'd1;
                        r_first    <= 1'b0;
                        if (!r_first && (r_gap != c_PERIOD)) begin
                            r_period_err <= 1'b1;
                        end
                        r_state <= c_HOLD;
                    end else if (w_char) begin
                        if (w_room) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end else begin
                            r_overflow_err <= 1'b1;
                        end
                    end
                end
                c_HOLD: begin
                    if (line_ready) begin
                        r_state <= (r_msg_cnt == c_TOTAL) ? c_FIN : c_RECV;
                    end
                end
                c_FIN:   r_state <= c_FIN;
                default: r_state <= c_RECV;
            endcase
        end
    end

    // Buffer is not reset; a discarded line is simply overwritten later.
    always_ff @(posedge clk) begin
        if (w_char && w_room) begin
            r_buf[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    assign in_ready     = (r_state == c_RECV) && !rst;
    assign line_valid   = (r_state == c_HOLD);
    assign done         = (r_state == c_FIN);
    assign line_len     = r_line_len;
    assign rd_data      = r_buf[rd_addr];
    assign msg_cnt      = r_msg_cnt;
    assign period_err   = r_period_err;
    assign overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_greeting_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_greeting_rx
// Purpose  : Directed self-checking bench; unit A (MAX_LEN=4, TOTAL=2) and
//            unit B (MAX_LEN=32, TOTAL=5) share one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_greeting_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       line_ready = 1'b0;
    logic [4:0] rd_addr = 5'd0;

    logic        a_in_ready, a_line_valid, a_period_err, a_overflow_err, a_done;
    logic [2:0]  a_line_len;
    logic [7:0]  a_rd_data;
    logic [31:0] a_msg_cnt;
    logic        b_in_ready, b_line_valid, b_period_err, b_overflow_err, b_done;
    logic [5:0]  b_line_len;
    logic [7:0]  b_rd_data;
    logic [31:0] b_msg_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_term = 0;

    greeting_rx #(.MAX_LEN(4), .PERIOD(20), .TOTAL(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .line_valid(a_line_valid), .line_ready(line_ready),
        .line_len(a_line_len), .rd_addr(rd_addr[1:0]), .rd_data(a_rd_data),
        .msg_cnt(a_msg_cnt), .period_err(a_period_err),
        .overflow_err(a_overflow_err), .done(a_done)
    );

    greeting_rx #(.MAX_LEN(32), .PERIOD(20), .TOTAL(5)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .line_valid(b_line_valid), .line_ready(line_ready),
        .line_len(b_line_len), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .msg_cnt(b_msg_cnt), .period_err(b_period_err),
        .overflow_err(b_overflow_err), .done(b_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        line_ready = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        t_term = 0;
    endtask

    // Sends the characters of s, then a terminator exactly gap edges after the previous one.
    task automatic send_line(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
        end
        in_valid = 1'b0;
        if (gap > 0) begin
            while (cyc + 1 < t_term + gap) tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h0A;
        tick();
        in_valid = 1'b0;
        t_term   = cyc;
    endtask

    task automatic release_line();
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", b_in_ready); end
        checks++; if (b_line_valid !== 1'b0) begin errors++; $display("FAIL rst_line_valid got %0b exp 0", b_line_valid); end
        checks++; if (b_line_len !== 6'd0) begin errors++; $display("FAIL rst_line_len got %0d exp 0", b_line_len); end
        checks++; if (b_msg_cnt !== 32'd0) begin errors++; $display("FAIL rst_msg_cnt got %0d exp 0", b_msg_cnt); end
        checks++; if ({b_period_err, b_overflow_err, b_done} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {b_period_err, b_overflow_err, b_done}); end
        checks++; if ({a_in_ready, a_line_valid, a_done} !== 3'b000) begin errors++; $display("FAIL rst_a_flags got %b exp 000", {a_in_ready, a_line_valid, a_done}); end
        do_reset();
        tick();
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0b exp 1", b_in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        send_line("Hi", 0);
        checks++; if (b_line_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got %0b exp 1", b_line_valid); end
        checks++; if (b_line_len !== 6'd2) begin errors++; $display("FAIL basic_len1 got %0d exp 2", b_line_len); end
        rd_addr = 5'd0; #1;
        checks++; if (b_rd_data !== 8'h48) begin errors++; $display("FAIL basic_rd0 got %0h exp 48", b_rd_data); end
        rd_addr = 5'd1; #1;
        checks++; if (b_rd_data !== 8'h69) begin errors++; $display("FAIL basic_rd1 got %0h exp 69", b_rd_data); end
        checks++; if (b_msg_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt1 got %0d exp 1", b_msg_cnt); end
        release_line();
        send_line("Yo", 20);
        rd_addr = 5'd0; #1;
        checks++; if (b_line_len !== 6'd2) begin errors++; $display("FAIL basic_len2 got %0d exp 2", b_line_len); end
        checks++; if (b_rd_data !== 8'h59) begin errors++; $display("FAIL basic_rd2 got %0h exp 59", b_rd_data); end
        checks++; if (b_msg_cnt !== 32'd2) begin errors++; $display("FAIL basic_cnt2 got %0d exp 2", b_msg_cnt); end
        checks++; if (b_period_err !== 1'b0) begin errors++; $display("FAIL basic_perr got %0b exp 0", b_period_err); end
        release_line();
    endtask

    task automatic test_period();
        do_reset();
        send_line("Hi", 0);
        release_line();
        send_line("Yo", 19);
        checks++; if (b_period_err !== 1'b1) begin errors++; $display("FAIL period_set got %0b exp 1", b_period_err); end
        release_line();
        send_line("Ok", 20);
        checks++; if (b_period_err !== 1'b1) begin errors++; $display("FAIL period_sticky got %0b exp 1", b_period_err); end
        checks++; if (b_msg_cnt !== 32'd3) begin errors++; $display("FAIL period_cnt got %0d exp 3", b_msg_cnt); end
        release_line();
    endtask

    task automatic test_overflow();
        string exp_s = "ABCD";
        do_reset();
        send_line("ABCD", 0);
        checks++; if (a_line_len !== 3'd4) begin errors++; $display("FAIL ovf_full_len got %0d exp 4", a_line_len); end
        checks++; if (a_overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_full_flag got %0b exp 0", a_overflow_err); end
        release_line();
        send_line("ABCDEF", 0);
        checks++; if (a_line_len !== 3'd4) begin errors++; $display("FAIL ovf_len got %0d exp 4", a_line_len); end
        checks++; if (a_overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", a_overflow_err); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 5'(i); #1;
            checks++; if (a_rd_data !== exp_s[i]) begin errors++; $display("FAIL ovf_rd%0d got %0h exp %0h", i, a_rd_data, exp_s[i]); end
        end
        checks++; if (b_line_len !== 6'd6 || b_overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_wide got len %0d flag %0b exp 6 0", b_line_len, b_overflow_err); end
        release_line();
    endtask

    task automatic test_backpressure();
        do_reset();
        send_line("Hi", 0);
        rd_addr  = 5'd0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            checks++; if (b_in_ready !== 1'b0 || b_line_valid !== 1'b1) begin errors++; $display("FAIL hold_c%0d got ready %0b valid %0b exp 0 1", i, b_in_ready, b_line_valid); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (b_rd_data !== 8'h48 || b_line_len !== 6'd2) begin errors++; $display("FAIL hold_stable got %0h len %0d exp 48 2", b_rd_data, b_line_len); end
        checks++; if (b_msg_cnt !== 32'd1) begin errors++; $display("FAIL hold_cnt got %0d exp 1", b_msg_cnt); end
        release_line();
        checks++; if (b_in_ready !== 1'b1 || b_line_valid !== 1'b0) begin errors++; $display("FAIL hold_release got ready %0b valid %0b exp 1 0", b_in_ready, b_line_valid); end
    endtask

    task automatic test_done();
        do_reset();
        send_line("Hi", 0);
        release_line();
        send_line("Yo", 20);
        checks++; if (a_done !== 1'b0 || a_line_valid !== 1'b1) begin errors++; $display("FAIL done_early got done %0b valid %0b exp 0 1", a_done, a_line_valid); end
        release_line();
        checks++; if (a_done !== 1'b1 || a_in_ready !== 1'b0 || a_line_valid !== 1'b0) begin errors++; $display("FAIL done_fin got done %0b ready %0b valid %0b exp 1 0 0", a_done, a_in_ready, a_line_valid); end
        in_valid = 1'b1;
        in_data  = 8'h0A;
        repeat (3) tick();
        in_valid = 1'b0;
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        checks++; if (a_msg_cnt !== 32'd2) begin errors++; $display("FAIL done_cnt got %0d exp 2", a_msg_cnt); end
        checks++; if (a_done !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL done_stay got done %0b ready %0b exp 1 0", a_done, a_in_ready); end
    endtask

    task automatic test_midreset();
        do_reset();
        send_line("Hi", 0);
        release_line();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'h48 : ((i == 1) ? 8'h65 : 8'h6C);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (b_msg_cnt !== 32'd0 || b_line_len !== 6'd0) begin errors++; $display("FAIL mid_rst got cnt %0d len %0d exp 0 0", b_msg_cnt, b_line_len); end
        checks++; if (b_in_ready !== 1'b0 || b_line_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs got ready %0b valid %0b exp 0 0", b_in_ready, b_line_valid); end
        tick();
        rst    = 1'b0;
        t_term = 0;
        send_line("Ok", 0);
        rd_addr = 5'd0; #1;
        checks++; if (b_line_len !== 6'd2) begin errors++; $display("FAIL mid_len got %0d exp 2", b_line_len); end
        checks++; if (b_rd_data !== 8'h4F) begin errors++; $display("FAIL mid_rd0 got %0h exp 4f", b_rd_data); end
        checks++; if (b_msg_cnt !== 32'd1 || b_period_err !== 1'b0) begin errors++; $display("FAIL mid_cnt got cnt %0d perr %0b exp 1 0", b_msg_cnt, b_period_err); end
        release_line();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period();
        test_overflow();
        test_backpressure();
        test_done();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
